// File: rtl/mem_stage_ctrl_if.sv
// Data-cache request bus between the memory-stage sequencer (master) and the dcache (slave).
interface mem_stage_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              dmemREN;
    logic              dmemWEN;
    logic [ADDR_W-1:0] dmemaddr;
    logic [DATA_W-1:0] dmemstore;
    logic              dhit;
    logic [DATA_W-1:0] dmemload;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer: runs the dcache REN/WEN/dhit handshake, stalls the pipe, feeds MEM/WB.
// Optional load-linked/store-conditional tracking is enabled by defining MEM_STAGE_LLSC_EN.
module mem_stage_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              op_valid,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              LL,
    input  logic              SC,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic              pipe_advance,
    input  logic              flush_req,
    input  logic              snoop_inv,
    input  logic [ADDR_W-1:0] snoop_addr,
    mem_stage_ctrl_if.master  dbus,
    output logic              mem_stall,
    output logic [DATA_W-1:0] memwb_dmemload,
    output logic              memwb_writeEN,
    output logic              memwb_flush
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            state, state_n;
    logic              rd_q, wr_q, sc_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] load_q;
    logic              mem_op;
    logic              sc_fail;

    assign mem_op = op_valid & (MemRead | MemWrite);

`ifdef MEM_STAGE_LLSC_EN
    logic              ll_q;
    logic              link_valid;
    logic [ADDR_W-1:0] link_addr;

    assign sc_fail = SC & ~(link_valid & (link_addr == addr));

    // Clears are applied first so an LL completing on the same edge still re-arms the link.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ll_q       <= 1'b0;
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else begin
            if (state == IDLE && mem_op)
                ll_q <= LL;
            if (snoop_inv && snoop_addr == link_addr)
                link_valid <= 1'b0;
            if (state == REQ && dbus.dhit && wr_q && addr_q == link_addr)
                link_valid <= 1'b0;
            if (state == IDLE && mem_op && SC)
                link_valid <= 1'b0;
            if (state == REQ && dbus.dhit && ll_q) begin
                link_valid <= 1'b1;
                link_addr  <= addr_q;
            end
        end
    end
`else
    logic unused_llsc;
    assign sc_fail     = 1'b0;
    assign unused_llsc = ^{LL, snoop_inv, snoop_addr};
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            sc_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            load_q <= '0;
        end else begin
            if (state == IDLE && mem_op) begin
                rd_q   <= MemRead;
                wr_q   <= MemWrite;
                sc_q   <= SC;
                addr_q <= addr;
                data_q <= store_data;
                if (sc_fail)
                    load_q <= '0;
            end
            if (state == REQ && dbus.dhit) begin
                if (rd_q)
                    load_q <= dbus.dmemload;
                else if (sc_q)
                    load_q <= DATA_W'(1);
            end
        end
    end

    always_comb begin
        state_n        = state;
        mem_stall      = 1'b0;
        dbus.dmemREN   = 1'b0;
        dbus.dmemWEN   = 1'b0;
        dbus.dmemaddr  = '0;
        dbus.dmemstore = '0;
        memwb_dmemload = '0;
        case (state)
            IDLE: begin
                // Gated by nRST so the stall also drops while reset is held.
                mem_stall = mem_op & nRST;
                if (mem_op)
                    state_n = sc_fail ? DONE : REQ;
            end
            REQ: begin
                mem_stall      = 1'b1;
                dbus.dmemREN   = rd_q;
                dbus.dmemWEN   = wr_q;
                dbus.dmemaddr  = addr_q;
                dbus.dmemstore = data_q;
                if (dbus.dhit)
                    state_n = DONE;
            end
            DONE: begin
                memwb_dmemload = load_q;
                if (pipe_advance)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        memwb_writeEN = nRST & pipe_advance & ~mem_stall;
        memwb_flush   = flush_req & memwb_writeEN;
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus random traffic against a
// transaction-level reference model (LL/SC rules follow MEM_STAGE_LLSC_EN when defined).
module tb_mem_stage_ctrl;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        op_valid, MemRead, MemWrite, LL, SC;
    logic [31:0] addr, store_data;
    logic        pipe_advance, flush_req, snoop_inv;
    logic [31:0] snoop_addr;
    logic        mem_stall, memwb_writeEN, memwb_flush;
    logic [31:0] memwb_dmemload;

    mem_stage_ctrl_if #(.ADDR_W(32), .DATA_W(32)) dbus ();

    mem_stage_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .op_valid(op_valid), .MemRead(MemRead), .MemWrite(MemWrite),
        .LL(LL), .SC(SC), .addr(addr), .store_data(store_data), .pipe_advance(pipe_advance),
        .flush_req(flush_req), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr), .dbus(dbus),
        .mem_stall(mem_stall), .memwb_dmemload(memwb_dmemload), .memwb_writeEN(memwb_writeEN),
        .memwb_flush(memwb_flush)
    );

    always #5 CLK = ~CLK;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: one outstanding transaction, either on the bus or waiting for advance.
    bit          txn_open, txn_ready;
    bit          t_rd, t_wr, t_ll, t_sc;
    logic [31:0] t_addr, t_data, result;
    bit          link_valid;
    logic [31:0] link_addr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        txn_open = 0; txn_ready = 0; t_rd = 0; t_wr = 0; t_ll = 0; t_sc = 0;
        t_addr = '0; t_data = '0; result = '0; link_valid = 0; link_addr = '0;
    endtask

    // Compare every output against the model for the inputs currently applied.
    task automatic apply();
        bit idle, mem_op, e_stall, e_wen;
        #1;
        idle    = !txn_open && !txn_ready;
        mem_op  = op_valid && (MemRead || MemWrite);
        e_stall = nRST && (txn_open || (idle && mem_op));
        e_wen   = nRST && pipe_advance && !e_stall;
        check_val("dmemREN",   {31'b0, dbus.dmemREN}, {31'b0, nRST && txn_open && t_rd});
        check_val("dmemWEN",   {31'b0, dbus.dmemWEN}, {31'b0, nRST && txn_open && t_wr});
        check_val("dmemaddr",  dbus.dmemaddr,  (nRST && txn_open) ? t_addr : 32'h0);
        check_val("dmemstore", dbus.dmemstore, (nRST && txn_open) ? t_data : 32'h0);
        check_val("mem_stall", {31'b0, mem_stall}, {31'b0, e_stall});
        check_val("memwb_dmemload", memwb_dmemload, (nRST && txn_ready) ? result : 32'h0);
        check_val("memwb_writeEN", {31'b0, memwb_writeEN}, {31'b0, e_wen});
        check_val("memwb_flush", {31'b0, memwb_flush}, {31'b0, e_wen && flush_req});
    endtask

    // Advance the model across the coming rising edge, then move to the next falling edge.
    task automatic tick();
        bit was_idle, complete, mem_op, sc_ok;
        if (!nRST) begin
            model_reset();
        end else begin
            was_idle = !txn_open && !txn_ready;
            complete = txn_open && dbus.dhit;
            mem_op   = op_valid && (MemRead || MemWrite);
            sc_ok    = 1;
`ifdef MEM_STAGE_LLSC_EN
            sc_ok = !SC || (link_valid && link_addr == addr);
            if (snoop_inv && snoop_addr == link_addr) link_valid = 0;
            if (complete && t_wr && t_addr == link_addr) link_valid = 0;
            if (was_idle && mem_op && SC) link_valid = 0;
            if (complete && t_ll) begin
                link_valid = 1;
                link_addr  = t_addr;
            end
`endif
            if (was_idle && mem_op) begin
                t_rd = MemRead; t_wr = MemWrite; t_ll = LL; t_sc = SC;
                t_addr = addr; t_data = store_data;
                if (!sc_ok) begin
                    txn_ready = 1;
                    result    = 0;
                end else begin
                    txn_open = 1;
                end
            end else if (complete) begin
                txn_open  = 0;
                txn_ready = 1;
                if (t_rd)      result = dbus.dmemload;
                else if (t_sc) result = 32'd1;
            end else if (txn_ready && pipe_advance) begin
                txn_ready = 0;
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic set_op(input bit v, input bit rd, input bit wr, input bit ll, input bit sc,
                          input logic [31:0] a, input logic [31:0] d);
        op_valid = v; MemRead = rd; MemWrite = wr; LL = ll; SC = sc; addr = a; store_data = d;
    endtask

    // One memory op: dhit after lat wait cycles, then one advance with flush_req=fl.
    task automatic run_op(input string tag, input bit rd, input bit wr, input bit ll, input bit sc,
                          input logic [31:0] a, input logic [31:0] d, input int unsigned lat,
                          input logic [31:0] ld, input bit fl, input int unsigned exp_strobes,
                          input logic [31:0] exp_res);
        int unsigned strobes = 0;
        set_op(1, rd, wr, ll, sc, a, d);
        dbus.dhit = 0; pipe_advance = 0; flush_req = fl;
        apply();
        check_val({tag, "_stall_n"}, {31'b0, mem_stall}, 32'd1);
        tick();
        for (int unsigned i = 0; i < lat; i++) begin
            apply();
            strobes += (dbus.dmemREN || dbus.dmemWEN) ? 1 : 0;
            tick();
        end
        dbus.dhit = 1; dbus.dmemload = ld;
        apply();
        strobes += (dbus.dmemREN || dbus.dmemWEN) ? 1 : 0;
        tick();
        dbus.dhit = 0; op_valid = 0; pipe_advance = 1;
        apply();
        check_val({tag, "_strobe_cycles"}, strobes, exp_strobes);
        check_val({tag, "_result"}, memwb_dmemload, exp_res);
        check_val({tag, "_writeEN"}, {31'b0, memwb_writeEN}, 32'd1);
        check_val({tag, "_flush"}, {31'b0, memwb_flush}, {31'b0, fl});
        tick();
        pipe_advance = 0; flush_req = 0;
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] pool [4] = '{32'h100, 32'h104, 32'h300, 32'h304};
        return pool[$urandom_range(3)];
    endfunction

    initial begin
        int unsigned k;
        nRST = 0;
        set_op(0, 0, 0, 0, 0, '0, '0);
        pipe_advance = 0; flush_req = 0; snoop_inv = 0; snoop_addr = '0;
        dbus.dhit = 0; dbus.dmemload = '0;
        model_reset();
        @(negedge CLK);
        apply();
        tick();
        nRST = 1;
        apply();
        tick();

        // Load with late dhit, store with immediate dhit, ALU op, flush held across a store.
        run_op("load", 1, 0, 0, 0, 32'h100, 32'h0, 2, 32'hDEADBEEF, 0, 3, 32'hDEADBEEF);
        run_op("store", 0, 1, 0, 0, 32'h200, 32'h55AA55AA, 0, 32'h0, 0, 1, 32'hDEADBEEF);
        set_op(1, 0, 0, 0, 0, 32'h44, 32'h0);
        pipe_advance = 1;
        apply();
        check_val("alu_writeEN", {31'b0, memwb_writeEN}, 32'd1);
        check_val("alu_stall", {31'b0, mem_stall}, 32'd0);
        tick();
        pipe_advance = 0;
        run_op("flush", 0, 1, 0, 0, 32'h204, 32'h1234, 1, 32'h0, 1, 2, 32'hDEADBEEF);

`ifdef MEM_STAGE_LLSC_EN
        run_op("ll1", 1, 0, 1, 0, 32'h300, 32'h0, 0, 32'hA5A5, 0, 1, 32'hA5A5);
        run_op("sc_ok", 0, 1, 0, 1, 32'h300, 32'h77, 0, 32'h0, 0, 1, 32'd1);
        run_op("ll2", 1, 0, 1, 0, 32'h300, 32'h0, 0, 32'h5A5A, 0, 1, 32'h5A5A);
        set_op(0, 0, 0, 0, 0, '0, '0);
        snoop_inv = 1; snoop_addr = 32'h300;
        apply();
        tick();
        snoop_inv = 0;
        run_op("sc_fail", 0, 1, 0, 1, 32'h300, 32'h88, 0, 32'h0, 0, 0, 32'd0);
`else
        run_op("sc_plain", 0, 1, 0, 1, 32'h300, 32'h77, 0, 32'h0, 0, 1, 32'd1);
`endif

        // Reset while a load is on the bus; load_q must read back as zero afterwards.
        set_op(1, 1, 0, 0, 0, 32'h100, 32'h0);
        apply();
        tick();
        nRST = 0;
        apply();
        check_val("rst_ren", {31'b0, dbus.dmemREN}, 32'd0);
        check_val("rst_stall", {31'b0, mem_stall}, 32'd0);
        tick();
        nRST = 1; op_valid = 0;
        apply();
        tick();
        run_op("post_rst", 0, 1, 0, 0, 32'h104, 32'h9, 0, 32'h0, 0, 1, 32'h0);

        for (int unsigned c = 0; c < 800; c++) begin
            k = $urandom_range(5);
            case (k)
                0: set_op(0, 0, 0, 0, 0, pick_addr(), $urandom);
                1: set_op(1, 0, 0, 0, 0, pick_addr(), $urandom);
                2: set_op(1, 1, 0, 0, 0, pick_addr(), $urandom);
                3: set_op(1, 0, 1, 0, 0, pick_addr(), $urandom);
                4: set_op(1, 1, 0, 1, 0, pick_addr(), $urandom);
                default: set_op(1, 0, 1, 0, 1, pick_addr(), $urandom);
            endcase
            dbus.dhit     = ($urandom_range(9) < 4);
            dbus.dmemload = $urandom;
            pipe_advance  = ($urandom_range(9) < 6);
            flush_req     = ($urandom_range(4) == 0);
            snoop_inv     = ($urandom_range(7) == 0);
            snoop_addr    = pick_addr();
            apply();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
